// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, imem addressing and the IF/ID pipeline register.
// Optional misaligned-redirect fault machine enabled by IF_ALIGN_CHECK_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] fetch_count,
  output logic        fault,
  output logic [31:0] fault_addr
);

  logic [31:0] r_pc;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic        w_fault_state;
  logic        w_fault_take;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef IF_ALIGN_CHECK_EN
  typedef enum logic {S_RUN, S_FAULT} state_t;

  state_t      r_state;
  logic        r_fault;
  logic [31:0] r_fault_addr;

  assign w_fault_state = (r_state == S_FAULT);
  assign w_fault_take  = pc_src_e && (pc_target_e[1:0] != 2'b00);
  assign w_redirect_pc = pc_target_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_fault_take) begin
            r_state      <= S_FAULT;
            r_fault      <= 1'b1;
            r_fault_addr <= pc_target_e;
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;
`else
  // Without the checker, low target bits are dropped to keep fetch word-aligned.
  logic [1:0] w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = pc_target_e[1:0];
  assign w_fault_state    = 1'b0;
  assign w_fault_take     = 1'b0;
  assign w_redirect_pc    = {pc_target_e[31:2], 2'b00};
  assign fault            = 1'b0;
  assign fault_addr       = '0;
`endif

  // Redirect outranks stall_f; a faulting redirect leaves the PC untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_fault_state) begin
      r_pc <= r_pc;
    end else if (pc_src_e) begin
      if (!w_fault_take) r_pc <= w_redirect_pc;
    end else if (!stall_f) begin
      r_pc <= w_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_d     <= NOP_INSTR;
      r_pc_d        <= '0;
      r_pc_plus4_d  <= '0;
      r_valid_d     <= 1'b0;
      r_fetch_count <= '0;
    end else if (w_fault_state || flush_d) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= '0;
      r_pc_plus4_d <= '0;
      r_valid_d    <= 1'b0;
    end else if (!stall_d) begin
      r_instr_d     <= imem_rdata;
      r_pc_d        <= r_pc;
      r_pc_plus4_d  <= w_pc_plus4;
      r_valid_d     <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign pc_f        = r_pc;
  assign pc_plus4_f  = w_pc_plus4;
  assign instr_d     = r_instr_d;
  assign pc_d        = r_pc_d;
  assign pc_plus4_d  = r_pc_plus4_d;
  assign valid_d     = r_valid_d;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference model pushes expected state per cycle,
// popped and compared one time unit after each rising edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e, imem_rdata, imem_addr, pc_f, pc_plus4_f;
  logic [31:0] instr_d, pc_d, pc_plus4_d, fetch_count, fault_addr;
  logic        valid_d, fault;
  logic [31:0] mix = 32'h0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ mix;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fetch_count(fetch_count),
    .fault(fault), .fault_addr(fault_addr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic        valid;
    logic        chk_pcd;
    logic [31:0] cnt;
    logic        flt;
    logic [31:0] faddr;
  } exp_t;

  exp_t q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt, m_faddr;
  logic        m_valid, m_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] word;
    logic        take_fault;
    reset = rst; stall_f = sf; stall_d = sd; flush_d = fd; pc_src_e = ps; pc_target_e = tgt;
    word = m_pc ^ mix;
`ifdef IF_ALIGN_CHECK_EN
    take_fault = ps && (tgt[1:0] != 2'b00);
`else
    take_fault = 1'b0;
`endif
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
      m_cnt = 0; m_fault = 0; m_faddr = 0;
    end else begin
      if (m_fault || fd) begin
        m_instr = 32'h13; m_valid = 0;
      end else if (!sd) begin
        m_instr = word; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
      end
      if (!m_fault) begin
        if (take_fault) begin
          m_fault = 1; m_faddr = tgt;
        end else if (ps) m_pc = {tgt[31:2], 2'b00};
        else if (!sf) m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.instr = m_instr; e.pcd = m_pcd; e.pc4d = m_pc4d; e.valid = m_valid;
    e.chk_pcd = m_valid || rst; e.cnt = m_cnt; e.flt = m_fault; e.faddr = m_faddr;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("pc_f", pc_f, e.pc);
      check("imem_addr", imem_addr, e.pc);
      check("pc_plus4_f", pc_plus4_f, e.pc + 32'd4);
      check("instr_d", instr_d, e.instr);
      check("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
      if (e.chk_pcd) begin
        check("pc_d", pc_d, e.pcd);
        check("pc_plus4_d", pc_plus4_d, e.pc4d);
      end
      check("fetch_count", fetch_count, e.cnt);
      check("fault", {31'd0, fault}, {31'd0, e.flt});
      check("fault_addr", fault_addr, e.faddr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] cnt_hold;
    m_pc = 0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
    m_cnt = 0; m_fault = 0; m_faddr = 0;
    reset = 1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    #2;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 32'h80);
    check("rst_pc4", pc_plus4_f, 32'h4);
    check("rst_instr", instr_d, 32'h13);

    // Three free-running fetches with word == address
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    check("run3_pc", pc_f, 32'hC);
    check("run3_instr", instr_d, 32'h8);
    check("run3_pcd", pc_d, 32'h8);
    check("run3_pc4d", pc_plus4_d, 32'hC);
    check("run3_cnt", fetch_count, 32'd3);

    cycle(0, 0, 0, 0, 0, 0);
    check("at10", pc_f, 32'h10);
    repeat (2) cycle(0, 1, 1, 0, 0, 0);
    check("stall_pc", pc_f, 32'h10);
    check("stall_cnt", fetch_count, 32'd4);
    cycle(0, 0, 0, 0, 0, 0);
    check("rel_pc", pc_f, 32'h14);
    check("rel_pcd", pc_d, 32'h10);

    // stall_f only: same PC reloaded and counted
    repeat (2) cycle(0, 1, 0, 0, 0, 0);
    check("sf_only_cnt", fetch_count, 32'd7);

    cnt_hold = fetch_count;
    cycle(0, 1, 0, 1, 1, 32'h40);
    check("redir_pc", pc_f, 32'h40);
    check("redir_instr", instr_d, 32'h13);
    check("redir_cnt", fetch_count, cnt_hold);

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    check("flush_stall_valid", {31'd0, valid_d}, 32'd0);

    // Redirect without flush loads the wrong-path word as valid
    cycle(0, 0, 0, 0, 1, 32'h200);
    check("wrongpath_valid", {31'd0, valid_d}, 32'd1);

    mix = 32'hDEAD_0000;
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_pc", pc_f, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4_f, 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    check("wrap_pc0", pc_f, 32'h0);

    cycle(0, 0, 0, 0, 1, 32'h42);
`ifdef IF_ALIGN_CHECK_EN
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_faddr", fault_addr, 32'h42);
    repeat (3) cycle(0, 0, 0, 0, 0, 0);
    check("mis_valid", {31'd0, valid_d}, 32'd0);
`else
    check("mis_pc", pc_f, 32'h40);
    check("mis_fault", {31'd0, fault}, 32'd0);
`endif
    cycle(1, 1, 1, 0, 0, 0);
    check("rst_mid_pc", pc_f, 32'h0);

    // Randomised traffic
    for (int unsigned i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      if (i == 200) mix = 32'h1234_5678;
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
